wb_arbiter_2m: RTL and testbench

WB_ARBITER_2M -- requirements
Module: wb_arbiter_2m

---
 rtl/wb_arb_pkg.sv | 14 +
 rtl/wb_arbiter_2m_if.sv | 24 ++
 rtl/wb_arb_watchdog.sv | 33 +++
 rtl/wb_arbiter_2m.sv | 165 ++++++++++++++++
 tb/tb_wb_arbiter_2m.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
// Watchdog sizing applies only when WB_ARB_TIMEOUT_EN is defined.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN0 = 2'b01,
    OWN1 = 2'b10
  } arb_state_e;

  // Wide enough for the largest legal TIMEOUT_CYCLES (255).
  localparam int WDOG_CNT_W = 8;

endpackage

// File: rtl/wb_arbiter_2m_if.sv
// Pipelined Wishbone request/response bundle; master drives requests,
// slave drives responses.
interface wb_arbiter_2m_if;

  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] addr;
  logic [31:0] data;
  logic        ack;
  logic        stall;
  logic [31:0] rdata;

  modport master (
    output cyc, stb, we, addr, data,
    input  ack, stall, rdata
  );

  modport slave (
    input  cyc, stb, we, addr, data,
    output ack, stall, rdata
  );

endinterface

// File: rtl/wb_arb_watchdog.sv
// Counts consecutive ack-less owned cycles and flags expiry on the last one.
// Instantiated only when WB_ARB_TIMEOUT_EN is defined.
module wb_arb_watchdog
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic ack,
  input  logic restart,
  output logic expire
);

  localparam logic [WDOG_CNT_W-1:0] LIMIT = WDOG_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [WDOG_CNT_W-1:0] count_r;

  assign expire = enable && !ack && (count_r == LIMIT);

  // Ack-less cycle counter; any ack, idle bus or owner change starts over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_r <= {WDOG_CNT_W{1'b0}};
    end else if (!enable || ack || restart) begin
      count_r <= {WDOG_CNT_W{1'b0}};
    end else begin
      count_r <= count_r + WDOG_CNT_W'(1);
    end
  end

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter onto one shared slave.
// Define WB_ARB_TIMEOUT_EN to add the ack watchdog with forced release.
module wb_arbiter_2m
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ID_WIDTH       = 1
) (
  input  logic                clk,
  input  logic                reset_n,
  wb_arbiter_2m_if.slave      m0,
  wb_arbiter_2m_if.slave      m1,
  wb_arbiter_2m_if.master     s,
  output logic                gnt_valid,
  output logic [ID_WIDTH-1:0] gnt_id,
  output logic                timeout_o
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter_2m: TIMEOUT_CYCLES out of range 2..255");
  end

  arb_state_e          state_r;
  arb_state_e          next_state_s;
  logic                last_r;
  logic                req0_s;
  logic                req1_s;
  logic                expire_s;
  logic                gnt_valid_r;
  logic [ID_WIDTH-1:0] gnt_id_r;

`ifdef WB_ARB_TIMEOUT_EN
  logic [1:0] mask_r;
  logic       restart_s;
  logic       timeout_r;

  assign restart_s = (next_state_s != state_r);

  wb_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (state_r != IDLE),
    .ack     (s.ack),
    .restart (restart_s),
    .expire  (expire_s)
  );

  // A timed-out master stays out of arbitration until it drops cyc.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_r <= 2'b00;
    end else begin
      if (expire_s && state_r == OWN0) mask_r[0] <= 1'b1;
      else if (!m0.cyc)                mask_r[0] <= 1'b0;
      else                             mask_r[0] <= mask_r[0];
      if (expire_s && state_r == OWN1) mask_r[1] <= 1'b1;
      else if (!m1.cyc)                mask_r[1] <= 1'b0;
      else                             mask_r[1] <= mask_r[1];
    end
  end

  // One-cycle pulse coinciding with the first cycle after forced release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timeout_r <= 1'b0;
    end else begin
      timeout_r <= expire_s;
    end
  end

  assign req0_s    = m0.cyc && !mask_r[0];
  assign req1_s    = m1.cyc && !mask_r[1];
  assign timeout_o = timeout_r;
`else
  assign expire_s  = 1'b0;
  assign req0_s    = m0.cyc;
  assign req1_s    = m1.cyc;
  assign timeout_o = 1'b0;
`endif

  // Ownership: hold while owner keeps cyc, hand over directly, tie by round-robin.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req0_s && req1_s) next_state_s = last_r ? OWN0 : OWN1;
        else if (req0_s)      next_state_s = OWN0;
        else if (req1_s)      next_state_s = OWN1;
        else                  next_state_s = IDLE;
      end
      OWN0: begin
        if (expire_s || !m0.cyc) next_state_s = req1_s ? OWN1 : IDLE;
        else                     next_state_s = OWN0;
      end
      OWN1: begin
        if (expire_s || !m1.cyc) next_state_s = req0_s ? OWN0 : IDLE;
        else                     next_state_s = OWN1;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State, round-robin history and registered grant outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      last_r      <= 1'b1;
      gnt_valid_r <= 1'b0;
      gnt_id_r    <= {ID_WIDTH{1'b0}};
    end else begin
      state_r     <= next_state_s;
      gnt_valid_r <= (next_state_s != IDLE);
      gnt_id_r    <= ID_WIDTH'(next_state_s == OWN1);
      if (next_state_s == OWN0)      last_r <= 1'b0;
      else if (next_state_s == OWN1) last_r <= 1'b1;
      else                           last_r <= last_r;
    end
  end

  assign gnt_valid = gnt_valid_r;
  assign gnt_id    = gnt_id_r;

  // Route the owner to the slave; the non-owner sees a stalled, silent bus.
  always_comb begin
    s.cyc    = 1'b0;
    s.stb    = 1'b0;
    s.we     = 1'b0;
    s.addr   = 32'h0000_0000;
    s.data   = 32'h0000_0000;
    m0.ack   = 1'b0;
    m0.stall = 1'b1;
    m0.rdata = 32'h0000_0000;
    m1.ack   = 1'b0;
    m1.stall = 1'b1;
    m1.rdata = 32'h0000_0000;
    case (state_r)
      OWN0: begin
        s.cyc    = m0.cyc;
        s.stb    = m0.stb;
        s.we     = m0.we;
        s.addr   = m0.addr;
        s.data   = m0.data;
        m0.ack   = s.ack;
        m0.stall = s.stall;
        m0.rdata = s.rdata;
      end
      OWN1: begin
        s.cyc    = m1.cyc;
        s.stb    = m1.stb;
        s.we     = m1.we;
        s.addr   = m1.addr;
        s.data   = m1.data;
        m1.ack   = s.ack;
        m1.stall = s.stall;
        m1.rdata = s.rdata;
      end
      default: begin
        s.cyc = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m; watchdog expectations follow WB_ARB_TIMEOUT_EN.
module tb_wb_arbiter_2m;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       gnt_valid;
  logic [0:0] gnt_id;
  logic       timeout_o;
  int         check_cnt = 0;
  int         error_cnt = 0;

  wb_arbiter_2m_if m0_bus ();
  wb_arbiter_2m_if m1_bus ();
  wb_arbiter_2m_if s_bus ();

  wb_arbiter_2m #(
    .TIMEOUT_CYCLES(16),
    .ID_WIDTH      (1)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .m0        (m0_bus),
    .m1        (m1_bus),
    .s         (s_bus),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout_o (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) begin
      error_cnt++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #2;
  endtask

  task automatic drive_m0(input logic cyc, input logic we, input logic [31:0] addr, input logic [31:0] data);
    m0_bus.cyc  = cyc;
    m0_bus.stb  = cyc;
    m0_bus.we   = we;
    m0_bus.addr = addr;
    m0_bus.data = data;
  endtask

  task automatic drive_m1(input logic cyc, input logic we, input logic [31:0] addr, input logic [31:0] data);
    m1_bus.cyc  = cyc;
    m1_bus.stb  = cyc;
    m1_bus.we   = we;
    m1_bus.addr = addr;
    m1_bus.data = data;
  endtask

  initial begin
    reset_n = 1'b0;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.ack   = 1'b0;
    s_bus.stall = 1'b0;
    s_bus.rdata = 32'h0;

    #12;
    chk_eq("rst_gnt_valid", gnt_valid, 32'd0);
    chk_eq("rst_gnt_id", gnt_id, 32'd0);
    chk_eq("rst_timeout", timeout_o, 32'd0);
    chk_eq("rst_s_cyc", s_bus.cyc, 32'd0);
    chk_eq("rst_m0_stall", m0_bus.stall, 32'd1);
    @(negedge clk) reset_n = 1'b1;
    step;

    // m0 single write
    drive_m0(1'b1, 1'b1, 32'h3000_0000, 32'h0000_00A5);
    #1;
    chk_eq("req_cycle_s_cyc", s_bus.cyc, 32'd0);
    chk_eq("req_cycle_gnt", gnt_valid, 32'd0);
    step;
    chk_eq("w_gnt_valid", gnt_valid, 32'd1);
    chk_eq("w_gnt_id", gnt_id, 32'd0);
    chk_eq("w_s_cyc", s_bus.cyc, 32'd1);
    chk_eq("w_s_we", s_bus.we, 32'd1);
    chk_eq("w_s_addr", s_bus.addr, 32'h3000_0000);
    chk_eq("w_s_data", s_bus.data, 32'h0000_00A5);
    chk_eq("w_m0_stall", m0_bus.stall, 32'd0);
    chk_eq("w_m1_stall", m1_bus.stall, 32'd1);
    s_bus.ack = 1'b1;
    #1;
    chk_eq("w_m0_ack", m0_bus.ack, 32'd1);
    chk_eq("w_m1_ack", m1_bus.ack, 32'd0);
    step;
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.ack = 1'b0;
    step;
    chk_eq("w_idle_gnt", gnt_valid, 32'd0);
    chk_eq("w_idle_s_addr", s_bus.addr, 32'h0);

    // m1 read
    drive_m1(1'b1, 1'b0, 32'h3000_0004, 32'h0);
    step;
    chk_eq("r_gnt_id", gnt_id, 32'd1);
    chk_eq("r_s_addr", s_bus.addr, 32'h3000_0004);
    s_bus.ack   = 1'b1;
    s_bus.rdata = 32'h0000_0005;
    #1;
    chk_eq("r_m1_rdata", m1_bus.rdata, 32'h5);
    chk_eq("r_m0_rdata", m0_bus.rdata, 32'h0);
    chk_eq("r_m1_ack", m1_bus.ack, 32'd1);
    chk_eq("r_m0_ack", m0_bus.ack, 32'd0);
    step;
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.ack   = 1'b0;
    s_bus.rdata = 32'h0;
    step;
    chk_eq("r_idle_gnt", gnt_valid, 32'd0);

    // contended back-to-back: expect 0,1,0,1 with no idle gap
    drive_m0(1'b1, 1'b1, 32'h3000_0008, 32'h1111_0000);
    drive_m1(1'b1, 1'b0, 32'h3000_000C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk_eq("rr_gnt_valid", gnt_valid, 32'd1);
      chk_eq("rr_gnt_id", gnt_id, 32'(i % 2));
      s_bus.ack = 1'b1;
      #1;
      chk_eq("rr_owner_ack", (i % 2 == 0) ? m0_bus.ack : m1_bus.ack, 32'd1);
      s_bus.ack = 1'b0;
      if (i % 2 == 0) begin
        m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
        m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
      end else begin
        m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
        m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
      end
    end
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step;
    chk_eq("rr_idle_gnt", gnt_valid, 32'd0);

    // m0 targets an unresponsive address while m1 waits
    drive_m0(1'b1, 1'b1, 32'h3000_0010, 32'h0);
    step;
    chk_eq("wd_gnt_id0", gnt_id, 32'd0);
    drive_m1(1'b1, 1'b0, 32'h3000_0014, 32'h0);
    for (int k = 1; k < 16; k++) begin
      step;
      chk_eq("wd_hold_gnt", gnt_id, 32'd0);
      chk_eq("wd_hold_to", timeout_o, 32'd0);
    end
    step;
`ifdef WB_ARB_TIMEOUT_EN
    chk_eq("wd_release_gnt", gnt_id, 32'd1);
    chk_eq("wd_release_valid", gnt_valid, 32'd1);
    chk_eq("wd_pulse", timeout_o, 32'd1);
    step;
    chk_eq("wd_pulse_end", timeout_o, 32'd0);
    chk_eq("wd_m1_holds", gnt_id, 32'd1);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step;
    chk_eq("wd_masked_a", gnt_valid, 32'd0);
    step;
    chk_eq("wd_masked_b", gnt_valid, 32'd0);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step;
    drive_m0(1'b1, 1'b0, 32'h3000_0010, 32'h0);
    step;
    chk_eq("wd_regrant_valid", gnt_valid, 32'd1);
    chk_eq("wd_regrant_id", gnt_id, 32'd0);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step;
`else
    chk_eq("nowd_still_m0", gnt_id, 32'd0);
    chk_eq("nowd_no_pulse", timeout_o, 32'd0);
    drive_m0(1'b0, 1'b0, 32'h0, 32'h0);
    step;
    chk_eq("nowd_handover", gnt_id, 32'd1);
    chk_eq("nowd_handover_valid", gnt_valid, 32'd1);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    step;
`endif
    chk_eq("wd_end_idle", gnt_valid, 32'd0);

    // reset in the middle of an m1 transfer
    drive_m1(1'b1, 1'b1, 32'h3000_0018, 32'h0000_0077);
    step;
    chk_eq("rst_mid_own1", gnt_id, 32'd1);
    chk_eq("rst_mid_s_cyc_pre", s_bus.cyc, 32'd1);
    s_bus.ack = 1'b1;
    reset_n   = 1'b0;
    #1;
    chk_eq("rst_mid_s_cyc", s_bus.cyc, 32'd0);
    chk_eq("rst_mid_s_stb", s_bus.stb, 32'd0);
    chk_eq("rst_mid_gnt", gnt_valid, 32'd0);
    chk_eq("rst_mid_m1_ack", m1_bus.ack, 32'd0);
    step;
    chk_eq("rst_held_m1_ack", m1_bus.ack, 32'd0);
    drive_m1(1'b0, 1'b0, 32'h0, 32'h0);
    s_bus.ack = 1'b0;
    reset_n   = 1'b1;
    step;
    chk_eq("rst_after_gnt", gnt_valid, 32'd0);

    $display("CHECKS %0d ERRORS %0d", check_cnt, error_cnt);
    $finish;
  end

endmodule
